scm_register_file_nr_1w: RTL and testbench

SCM_REGISTER_FILE_NR_1W -- requirements
Module: scm_register_file_nr_1w

---
 rtl/scm_register_file_nr_1w.sv | 176 +++++++++++++++++
 tb/tb_scm_register_file_nr_1w.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/scm_register_file_nr_1w.sv
// +----------------------------------------------------------------------------+
// | Module  : scm_register_file_nr_1w                                          |
// | Latch-based register file: one write port, NUM_RPORTS read ports, and a    |
// | post-reset clear sequence. Optional macro: SCM_RF_BYPASS_EN (same-edge     |
// | write-to-read forwarding).                                                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module scm_register_file_nr_1w #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WORDS  = 2**ADDR_WIDTH,
   parameter int NUM_RPORTS = 2
) (
   input  logic                             clk,
   input  logic                             rst_n,
   output logic                             init_done_o,
   input  logic [NUM_RPORTS-1:0]            ReadEnable,
   input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] ReadAddr,
   output logic [NUM_RPORTS*DATA_WIDTH-1:0] ReadData,
   input  logic                             WriteEnable,
   input  logic [ADDR_WIDTH-1:0]            WriteAddr,
   input  logic [DATA_WIDTH-1:0]            WriteData,
   input  logic [DATA_WIDTH/8-1:0]          WriteBE
);

   localparam int                   c_NumBytes = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0]   c_NumWords = (ADDR_WIDTH+1)'(NUM_WORDS);
   localparam logic [ADDR_WIDTH-1:0] c_LastWord = ADDR_WIDTH'(NUM_WORDS - 1);

   typedef enum logic [0:0] {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t                          r_state;
   state_t                          w_stateNext;
   logic [ADDR_WIDTH-1:0]           r_cnt;

   logic                            w_wReq;
   logic [ADDR_WIDTH-1:0]           w_wAddrSel;
   logic [DATA_WIDTH-1:0]           w_wDataSel;
   logic [c_NumBytes-1:0]           w_wBESel;
   logic [NUM_WORDS-1:0]            w_wOneHot;

   logic                            r_wValid;
   logic [NUM_WORDS-1:0]            r_wOneHot;
   logic [DATA_WIDTH-1:0]           r_WDataInt;
   logic [c_NumBytes-1:0]           r_BEInt;
`ifdef SCM_RF_BYPASS_EN
   logic [ADDR_WIDTH-1:0]           r_wAddr;
`endif

   logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] w_mem;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_INIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_stateNext;
         if (r_state == ST_INIT)
            r_cnt <= (r_cnt == c_LastWord) ? '0 : r_cnt + ADDR_WIDTH'(1);
      end
   end

   // During INIT the clear sequence owns the write pipeline.
   always_comb begin
      w_stateNext = r_state;
      w_wReq      = 1'b0;
      w_wAddrSel  = WriteAddr;
      w_wDataSel  = WriteData;
      w_wBESel    = WriteBE;
      case (r_state)
         ST_INIT: begin
            w_wReq     = 1'b1;
            w_wAddrSel = r_cnt;
            w_wDataSel = '0;
            w_wBESel   = '1;
            if (r_cnt == c_LastWord)
               w_stateNext = ST_READY;
         end
         ST_READY: begin
            w_wReq = WriteEnable && ({1'b0, WriteAddr} < c_NumWords);
         end
         default: w_stateNext = ST_INIT;
      endcase
   end

   assign init_done_o = (r_state == ST_READY);

   always_comb begin
      w_wOneHot = '0;
      for (int w = 0; w < NUM_WORDS; w++)
         w_wOneHot[w] = (w_wAddrSel == ADDR_WIDTH'(w));
   end

   // ---------------- write pipeline ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wValid <= 1'b0;
      end else begin
         r_wValid <= w_wReq;
      end
      if (w_wReq) begin
         r_wOneHot  <= w_wOneHot;
         r_WDataInt <= w_wDataSel;
         r_BEInt    <= w_wBESel;
`ifdef SCM_RF_BYPASS_EN
         r_wAddr    <= w_wAddrSel;
`endif
      end
   end

   // ---------------- latch array ----------------
   // Byte latches open in the low phase after the write edge, when the
   // pipeline registers are stable, so a read captured at the next edge sees them.
   for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
      for (genvar b = 0; b < c_NumBytes; b++) begin : g_byte
         logic       w_gate;
         logic [7:0] r_lat;
         assign w_gate = ~clk & r_wValid & r_wOneHot[w] & r_BEInt[b];
         always_latch begin
            if (w_gate)
               r_lat <= r_WDataInt[b*8 +: 8];
         end
         assign w_mem[w][b*8 +: 8] = r_lat;
      end
   end

   // ---------------- read ports ----------------
   for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
      logic [ADDR_WIDTH-1:0] r_rAddr;
      logic                  r_rValid;
      logic                  r_rInRange;
      logic [DATA_WIDTH-1:0] w_rWord;
      logic [DATA_WIDTH-1:0] w_rOut;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_rValid <= 1'b0;
         end else if (r_state == ST_READY && ReadEnable[p]) begin
            r_rValid   <= 1'b1;
            r_rAddr    <= ReadAddr[p*ADDR_WIDTH +: ADDR_WIDTH];
            r_rInRange <= {1'b0, ReadAddr[p*ADDR_WIDTH +: ADDR_WIDTH]} < c_NumWords;
         end
      end

      always_comb begin
         w_rWord = '0;
         for (int w = 0; w < NUM_WORDS; w++)
            if (r_rAddr == ADDR_WIDTH'(w))
               w_rWord = w_mem[w];
      end

`ifdef SCM_RF_BYPASS_EN
      // Merging is idempotent, so the output is steady across the latch update.
      always_comb begin
         w_rOut = w_rWord;
         if (r_wValid && r_wAddr == r_rAddr)
            for (int b = 0; b < c_NumBytes; b++)
               if (r_BEInt[b])
                  w_rOut[b*8 +: 8] = r_WDataInt[b*8 +: 8];
      end
`else
      assign w_rOut = w_rWord;
`endif

      assign ReadData[p*DATA_WIDTH +: DATA_WIDTH] = (r_rValid && r_rInRange) ? w_rOut : '0;
   end

endmodule

`default_nettype wire

// File: tb/tb_scm_register_file_nr_1w.sv
// Directed self-checking bench for scm_register_file_nr_1w (20 words, 2 read ports).
`default_nettype none

module tb_scm_register_file_nr_1w;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NW = 20;
   localparam int NP = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            init_done_o;
   logic [NP-1:0]   ReadEnable;
   logic [NP*AW-1:0] ReadAddr;
   logic [NP*DW-1:0] ReadData;
   logic            WriteEnable;
   logic [AW-1:0]   WriteAddr;
   logic [DW-1:0]   WriteData;
   logic [DW/8-1:0] WriteBE;

   int nTests = 0;
   int nFail  = 0;
   int cyc;

   always #5 clk = ~clk;

   scm_register_file_nr_1w #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW), .NUM_RPORTS(NP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .init_done_o(init_done_o),
      .ReadEnable(ReadEnable), .ReadAddr(ReadAddr), .ReadData(ReadData),
      .WriteEnable(WriteEnable), .WriteAddr(WriteAddr),
      .WriteData(WriteData), .WriteBE(WriteBE)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nTests++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] rd(input int p);
      return ReadData[p*DW +: DW];
   endfunction

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
      WriteEnable = 1'b1; WriteAddr = a; WriteData = d; WriteBE = be;
      tick();
      WriteEnable = 1'b0;
   endtask

   task automatic rdReq(input int p, input logic [AW-1:0] a);
      ReadEnable[p] = 1'b1;
      ReadAddr[p*AW +: AW] = a;
      tick();
      ReadEnable[p] = 1'b0;
   endtask

   task automatic waitInit(output int n);
      n = 0;
      while (!init_done_o && n < 100) begin
         tick();
         n++;
      end
   endtask

   initial begin
      rst_n = 1'b0; ReadEnable = '0; ReadAddr = '0;
      WriteEnable = 1'b0; WriteAddr = '0; WriteData = '0; WriteBE = '0;
      tick(); tick();
      check("reset_init_done", 32'(init_done_o), 32'd0);
      check("reset_rd0", rd(0), 32'h0);
      check("reset_rd1", rd(1), 32'h0);

      // Release reset with a write and reads pending; INIT must ignore them.
      rst_n = 1'b1;
      WriteEnable = 1'b1; WriteAddr = 5'd2; WriteData = 32'hFFFF_FFFF; WriteBE = 4'hF;
      ReadEnable = 2'b11; ReadAddr = {5'd2, 5'd2};
      cyc = 0;
      while (!init_done_o && cyc < 100) begin
         tick();
         cyc++;
         if (cyc == 5) begin
            check("init_rd0_zero", rd(0), 32'h0);
            check("init_rd1_zero", rd(1), 32'h0);
         end
      end
      WriteEnable = 1'b0; ReadEnable = 2'b00;
      check("init_cycles", 32'(cyc), 32'd20);

      for (int w = 0; w < NW; w++) begin
         rdReq(w % 2, AW'(w));
         check("clear_word", rd(w % 2), 32'h0);
      end

      wr(5'd3, 32'hDEAD_BEEF, 4'hF);
      rdReq(0, 5'd3);
      check("wr_rd_full", rd(0), 32'hDEAD_BEEF);
      wr(5'd3, 32'h1122_3344, 4'b0101);
      rdReq(0, 5'd3);
      check("wr_rd_be", rd(0), 32'hDE22_BE44);

      wr(5'd25, 32'hFFFF_FFFF, 4'hF);
      rdReq(1, 5'd25);
      check("rd_oob", rd(1), 32'h0);
      for (int w = 0; w < NW; w++) begin
         rdReq(0, AW'(w));
         check("oob_no_change", rd(0), (w == 3) ? 32'hDE22_BE44 : 32'h0);
      end

      wr(5'd7, 32'h1234_5678, 4'hF);
      ReadEnable = 2'b11; ReadAddr = {5'd7, 5'd7};
      tick();
      ReadEnable = 2'b00;
      check("same_word_p0", rd(0), 32'h1234_5678);
      check("same_word_p1", rd(1), 32'h1234_5678);
      for (int i = 0; i < 5; i++) begin
         rdReq(0, 5'd3);
         check("hold_p1", rd(1), 32'h1234_5678);
      end
      check("p0_moved", rd(0), 32'hDE22_BE44);

      wr(5'd7, 32'hFFFF_FFFF, 4'b0000);
      rdReq(1, 5'd7);
      check("be_zero", rd(1), 32'h1234_5678);

      // Same-edge write and read of word 5.
      wr(5'd5, 32'hAAAA_AAAA, 4'hF);
      WriteEnable = 1'b1; WriteAddr = 5'd5; WriteData = 32'h5555_5555; WriteBE = 4'b0011;
      ReadEnable[0] = 1'b1; ReadAddr[0 +: AW] = 5'd5;
      tick();
      WriteEnable = 1'b0; ReadEnable = 2'b00;
`ifdef SCM_RF_BYPASS_EN
      check("bypass_next", rd(0), 32'hAAAA_5555);
`endif
      tick();
      check("collide_after", rd(0), 32'hAAAA_5555);

      // Reset from READY, then again in the middle of INIT.
      wr(5'd4, 32'hCAFE_F00D, 4'hF);
      rst_n = 1'b0;
      tick();
      check("rst_ready_done", 32'(init_done_o), 32'd0);
      check("rst_ready_rd1", rd(1), 32'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("mid_init_done", 32'(init_done_o), 32'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      waitInit(cyc);
      check("reinit_cycles", 32'(cyc), 32'd20);
      rdReq(0, 5'd4);
      check("reinit_w4", rd(0), 32'h0);
      rdReq(1, 5'd3);
      check("reinit_w3", rd(1), 32'h0);
      rdReq(0, 5'd19);
      check("reinit_w19", rd(0), 32'h0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule

`default_nettype wire
